power_trigger: RTL and testbench
================================

POWER_TRIGGER -- requirements
Module: power_trigger

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: reset is asynchronous and active-high.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 enable  input  1  when low, state and counters freeze and strobes are ignored.
REQ-005 sample_in  input  32  {I[31:16], Q[15:0]}, two's complement.
REQ-006 sample_in_strobe  input  1  sample valid qualifier.
REQ-007 power_thres  input  16  unsigned threshold on |I|.
REQ-008 window_size  input  16  consecutive low samples that end a packet; 0 is treated as 1.
REQ-009 num_sample_to_skip  input  32  samples ignored after reset or reconfiguration.
REQ-010 num_sample_changed  input  1  one-cycle pulse that restarts the skip phase.
REQ-011 demod_is_ongoing  input  1  while high, the packet SHALL NOT be closed.
REQ-012 trigger  output  1  registered; high while a packet is believed present; gates the downstream short-preamble detector.
REQ-013 sync_short_reset  output  1  one-cycle pulse on trigger fall, used to reset the downstream detector.

Function
REQ-014 abs_i SHALL equal |I|, saturating -32768 to 32767; the sample is "high" iff abs_i > power_thres, otherwise "low".
REQ-015 FSM states: S_SKIP, S_IDLE, S_PACKET.
REQ-016 S_SKIP: skip_count increments on each strobe; when skip_count reaches num_sample_to_skip the FSM SHALL move to S_IDLE on that strobe; num_sample_to_skip = 0 SHALL give S_IDLE on the first strobe.
REQ-017 S_IDLE: a high sample SHALL set trigger=1 on the next cycle, clear low_count, and enter S_PACKET; a low sample keeps S_IDLE.
REQ-018 S_PACKET, high sample: low_count SHALL clear to 0.
REQ-019 S_PACKET, low sample: low_count SHALL increment, saturating at 0xFFFF.
REQ-020 S_PACKET, close condition: when low_count+1 reaches max(window_size,1) and demod_is_ongoing=0, the block SHALL clear trigger, pulse sync_short_reset for exactly one cycle, clear low_count, and enter S_IDLE.
REQ-021 If the close condition is met while demod_is_ongoing=1, the block SHALL hold S_PACKET with low_count saturated at its threshold; it SHALL close on the first strobe after demod_is_ongoing falls if that sample is low.
REQ-022 Latency: strobe at cycle n SHALL produce trigger/sync_short_reset changes at cycle n+1.
REQ-023 num_sample_changed from any state SHALL take priority over sample processing in the same cycle: enter S_SKIP, clear skip_count and low_count, clear trigger; pulse sync_short_reset if trigger was high.
REQ-024 enable=0 SHALL hold trigger and the FSM and force sync_short_reset=0; a strobe coincident with enable=0 is discarded.
REQ-025 Non-strobe cycles SHALL not alter counters or the FSM.

Reset
REQ-026 reset SHALL asynchronously set state=S_SKIP, skip_count=0, low_count=0, trigger=0, sync_short_reset=0.
REQ-027 Reset deassertion mid-packet SHALL restart the skip phase; there SHALL be no sync_short_reset pulse caused by reset itself.

Structure
REQ-028 State encoding, counter widths (16/32) and the saturation constant SHALL reside in the shared OFDM RX package.
REQ-029 The absolute-value saturation SHALL be one sub-module, abs_sat16 (combinational, 16-bit in/out).
REQ-030 The implementation SHALL have no multipliers; comparisons are unsigned.

Verification
REQ-031 skip=100, thres=1000, I=2000 constant: trigger stays 0 for strobes 1..100; it goes 1 one cycle after strobe 101.
REQ-032 In S_PACKET, window_size=80, 79 low samples then one high sample, then 80 low samples: trigger stays high through the first 80 and falls after the 80th of the final run; sync_short_reset is one pulse.
REQ-033 I=-32768, thres=32766: abs_i=32767, high, trigger asserts.
REQ-034 demod_is_ongoing=1 across 200 low samples with window_size=80: trigger stays 1; demod falls and the next low sample gives trigger 0 at +1 cycle.
REQ-035 num_sample_changed pulse coincident with a high strobe in S_PACKET: trigger falls, sync_short_reset pulses, and the FSM enters S_SKIP.
REQ-036 reset asserted mid-packet without a clock edge: trigger=0 immediately, and no sync_short_reset pulse follows.

Source files
------------

// File: rtl/power_trigger_pkg.sv
// Shared OFDM RX definitions: power-trigger FSM encoding, counter widths
// and saturation constants.
package power_trigger_pkg;

  typedef enum logic [1:0] {
    S_SKIP   = 2'd0,
    S_IDLE   = 2'd1,
    S_PACKET = 2'd2
  } state_t;

  localparam int SAMPLE_W   = 32;
  localparam int HALF_W     = 16;
  localparam int LOW_CNT_W  = 16;
  localparam int SKIP_CNT_W = 32;

  localparam logic [LOW_CNT_W-1:0]  LOW_CNT_MAX  = {LOW_CNT_W{1'b1}};
  localparam logic [SKIP_CNT_W-1:0] SKIP_CNT_MAX = {SKIP_CNT_W{1'b1}};
  localparam logic [HALF_W-1:0]     ABS_SAT_MAX  = 16'h7FFF;
  localparam logic [HALF_W-1:0]     ABS_NEG_MIN  = 16'h8000;

  // A zero window would never close a packet, so it behaves as one sample.
  function automatic logic [LOW_CNT_W-1:0] effective_window(input logic [LOW_CNT_W-1:0] win);
    return (win == '0) ? {{(LOW_CNT_W-1){1'b0}}, 1'b1} : win;
  endfunction

endpackage

// File: rtl/power_trigger_abs_sat16.sv
// Saturating absolute value of a 16-bit two's complement value;
// the most negative input maps to +32767.
module abs_sat16
  import power_trigger_pkg::*;
(
  input  logic [HALF_W-1:0] value,
  output logic [HALF_W-1:0] magnitude
);

  always_comb begin
    magnitude = value;
    if (value == ABS_NEG_MIN) begin
      magnitude = ABS_SAT_MAX;
    end else if (value[HALF_W-1]) begin
      magnitude = ~value + 16'd1;
    end
  end

endmodule

// File: rtl/power_trigger.sv
// Packet-presence trigger: skips a configurable number of samples, then
// raises trigger on the first strong sample and drops it after a run of weak ones.
module power_trigger
  import power_trigger_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic                  sample_in_strobe,
  input  logic [HALF_W-1:0]     power_thres,
  input  logic [LOW_CNT_W-1:0]  window_size,
  input  logic [SKIP_CNT_W-1:0] num_sample_to_skip,
  input  logic                  num_sample_changed,
  input  logic                  demod_is_ongoing,
  output logic                  trigger,
  output logic                  sync_short_reset
);

  state_t                state_reg, state_next;
  logic [SKIP_CNT_W-1:0] skip_count_reg, skip_count_next;
  logic [LOW_CNT_W-1:0]  low_count_reg, low_count_next;
  logic                  trigger_reg, trigger_next;
  logic                  sync_short_reset_reg, sync_short_reset_next;

  logic [HALF_W-1:0]     abs_i;
  logic                  sample_high;
  logic [LOW_CNT_W-1:0]  window_eff;
  logic [LOW_CNT_W-1:0]  low_count_inc;
  logic [SKIP_CNT_W-1:0] skip_count_inc;
  logic                  skip_done;
  logic                  window_reached;

  // Only the I rail carries the power decision; Q is carried but not used.
  logic sample_q_unused;
  assign sample_q_unused = ^sample_in[HALF_W-1:0];

  abs_sat16 u_abs_i (
    .value     (sample_in[SAMPLE_W-1:HALF_W]),
    .magnitude (abs_i)
  );

  assign sample_high    = (abs_i > power_thres);
  assign window_eff     = effective_window(window_size);
  assign low_count_inc  = (low_count_reg == LOW_CNT_MAX) ? LOW_CNT_MAX : low_count_reg + 16'd1;
  assign skip_count_inc = (skip_count_reg == SKIP_CNT_MAX) ? SKIP_CNT_MAX : skip_count_reg + 32'd1;

  // Widened compares so the +1 can never wrap around.
  assign skip_done      = ({1'b0, skip_count_reg} + 33'd1) >= {1'b0, num_sample_to_skip};
  assign window_reached = ({1'b0, low_count_reg} + 17'd1) >= {1'b0, window_eff};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg            <= S_SKIP;
      skip_count_reg       <= '0;
      low_count_reg        <= '0;
      trigger_reg          <= 1'b0;
      sync_short_reset_reg <= 1'b0;
    end else begin
      state_reg            <= state_next;
      skip_count_reg       <= skip_count_next;
      low_count_reg        <= low_count_next;
      trigger_reg          <= trigger_next;
      sync_short_reset_reg <= sync_short_reset_next;
    end
  end

  always_comb begin
    state_next            = state_reg;
    skip_count_next       = skip_count_reg;
    low_count_next        = low_count_reg;
    trigger_next          = trigger_reg;
    sync_short_reset_next = 1'b0;

    if (enable) begin
      if (num_sample_changed) begin
        // Reconfiguration wins over any sample arriving in the same cycle.
        state_next            = S_SKIP;
        skip_count_next       = '0;
        low_count_next        = '0;
        trigger_next          = 1'b0;
        sync_short_reset_next = trigger_reg;
      end else if (sample_in_strobe) begin
        unique case (state_reg)
          S_SKIP: begin
            skip_count_next = skip_count_inc;
            if (skip_done) begin
              state_next = S_IDLE;
            end
          end
          S_IDLE: begin
            if (sample_high) begin
              trigger_next   = 1'b1;
              low_count_next = '0;
              state_next     = S_PACKET;
            end
          end
          S_PACKET: begin
            if (sample_high) begin
              low_count_next = '0;
            end else if (window_reached) begin
              if (demod_is_ongoing) begin
                // Park at the threshold so the first low sample after
                // demodulation ends closes the packet immediately.
                low_count_next = window_eff;
              end else begin
                trigger_next          = 1'b0;
                sync_short_reset_next = 1'b1;
                low_count_next        = '0;
                state_next            = S_IDLE;
              end
            end else begin
              low_count_next = low_count_inc;
            end
          end
          default: begin
            state_next   = S_SKIP;
            trigger_next = 1'b0;
          end
        endcase
      end
    end
  end

  assign trigger          = trigger_reg;
  assign sync_short_reset = sync_short_reset_reg;

endmodule

// File: tb/tb_power_trigger.sv
// Self-checking bench for power_trigger: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_power_trigger;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] sample_in = '0;
  logic        sample_in_strobe = 1'b0;
  logic [15:0] power_thres = 16'd1000;
  logic [15:0] window_size = 16'd2;
  logic [31:0] num_sample_to_skip = '0;
  logic        num_sample_changed = 1'b0;
  logic        demod_is_ongoing = 1'b0;
  logic        trigger;
  logic        sync_short_reset;

  int errors = 0;
  int checks = 0;

  power_trigger dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .sample_in          (sample_in),
    .sample_in_strobe   (sample_in_strobe),
    .power_thres        (power_thres),
    .window_size        (window_size),
    .num_sample_to_skip (num_sample_to_skip),
    .num_sample_changed (num_sample_changed),
    .demod_is_ongoing   (demod_is_ongoing),
    .trigger            (trigger),
    .sync_short_reset   (sync_short_reset)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int PH_SKIP = 0, PH_IDLE = 1, PH_PACKET = 2;
  int     m_phase;
  longint m_skipped;
  int     m_lows;
  bit     m_trig, m_ssr;

  task automatic model_reset();
    m_phase = PH_SKIP; m_skipped = 0; m_lows = 0; m_trig = 0; m_ssr = 0;
  endtask

  task automatic model_step();
    int iv, mag, w;
    bit high;
    m_ssr = 0;
    iv  = int'($signed(sample_in[31:16]));
    mag = (iv < 0) ? -iv : iv;
    if (mag > 32767) mag = 32767;
    high = (mag > int'(power_thres));
    w = (window_size == 0) ? 1 : int'(window_size);
    if (!enable) return;
    if (num_sample_changed) begin
      m_ssr = m_trig; m_trig = 0; m_phase = PH_SKIP; m_skipped = 0; m_lows = 0;
    end else if (sample_in_strobe) begin
      if (m_phase == PH_SKIP) begin
        m_skipped++;
        if (m_skipped >= longint'(num_sample_to_skip)) m_phase = PH_IDLE;
      end else if (m_phase == PH_IDLE) begin
        if (high) begin m_phase = PH_PACKET; m_trig = 1; m_lows = 0; end
      end else begin
        if (high) m_lows = 0;
        else begin
          m_lows++;
          if (m_lows >= w) begin
            if (demod_is_ongoing) m_lows = w;
            else begin m_trig = 0; m_ssr = 1; m_lows = 0; m_phase = PH_IDLE; end
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b1; sample_in_strobe = 1'b0; num_sample_changed = 1'b0; demod_is_ongoing = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          en, stb, nsc, demod;
    logic [15:0] i_val, thr, win;
    logic [31:0] nskip;
    bit          exp_trig, exp_ssr;
  } vec_t;

  vec_t vecs[17];
  bit   seen, seen2;
  int   pulses;

  initial begin
    vecs[0]  = '{1,1,0,0, 16'h0000, 16'd1000,  16'd2, 32'd0, 0,0};
    vecs[1]  = '{1,1,0,0, 16'h8000, 16'd32766, 16'd2, 32'd0, 1,0};
    vecs[2]  = '{1,1,0,0, 16'h8001, 16'd32767, 16'd2, 32'd0, 1,0};
    vecs[3]  = '{0,1,0,0, 16'h0000, 16'd1000,  16'd2, 32'd0, 1,0};
    vecs[4]  = '{1,0,0,0, 16'h0000, 16'd1000,  16'd2, 32'd0, 1,0};
    vecs[5]  = '{1,1,0,0, 16'h0000, 16'd1000,  16'd2, 32'd0, 0,1};
    vecs[6]  = '{1,0,0,0, 16'h0000, 16'd1000,  16'd2, 32'd0, 0,0};
    vecs[7]  = '{1,1,0,0, 16'h7FFF, 16'd32766, 16'd2, 32'd0, 1,0};
    vecs[8]  = '{1,1,1,0, 16'h7FFF, 16'd32766, 16'd2, 32'd0, 0,1};
    vecs[9]  = '{1,1,0,0, 16'h7FFF, 16'd32766, 16'd2, 32'd0, 0,0};
    vecs[10] = '{1,1,0,0, 16'h7FFF, 16'd32766, 16'd2, 32'd0, 1,0};
    vecs[11] = '{0,1,1,0, 16'h7FFF, 16'd32766, 16'd2, 32'd0, 1,0};
    vecs[12] = '{1,1,0,0, 16'd1000, 16'd1000,  16'd0, 32'd0, 0,1};
    vecs[13] = '{1,1,0,0, 16'hFC17, 16'd1000,  16'd0, 32'd0, 1,0};
    vecs[14] = '{1,1,0,1, 16'h0000, 16'd1000,  16'd1, 32'd0, 1,0};
    vecs[15] = '{1,0,0,0, 16'h0000, 16'd1000,  16'd1, 32'd0, 1,0};
    vecs[16] = '{1,1,0,0, 16'h0000, 16'd1000,  16'd1, 32'd0, 0,1};

    // Reset state, checked while reset is still asserted.
    #2;
    check("reset_trigger", {31'd0, trigger}, 32'd0);
    check("reset_ssr", {31'd0, sync_short_reset}, 32'd0);
    num_sample_to_skip = 32'd0;
    apply_reset();

    for (int k = 0; k < 17; k++) begin
      enable = vecs[k].en; sample_in_strobe = vecs[k].stb; num_sample_changed = vecs[k].nsc;
      demod_is_ongoing = vecs[k].demod; sample_in = {vecs[k].i_val, 16'h1234};
      power_thres = vecs[k].thr; window_size = vecs[k].win; num_sample_to_skip = vecs[k].nskip;
      tick();
      $display("vec %0d: trig=%b ssr=%b (want %b %b)", k, trigger, sync_short_reset,
               vecs[k].exp_trig, vecs[k].exp_ssr);
      check($sformatf("vec%0d", k), {30'd0, trigger, sync_short_reset},
            {30'd0, vecs[k].exp_trig, vecs[k].exp_ssr});
    end
    enable = 1; sample_in_strobe = 0; num_sample_changed = 0; demod_is_ongoing = 0;

    // Skip phase of 100 samples with a constant strong input.
    num_sample_to_skip = 32'd100;
    apply_reset();
    power_thres = 16'd1000; window_size = 16'd80;
    sample_in = {16'd2000, 16'd0}; sample_in_strobe = 1;
    seen = 0;
    for (int k = 1; k <= 100; k++) begin tick(); seen |= trigger; end
    check("skip_hold", {31'd0, seen}, 32'd0);
    tick();
    check("skip_exit", {31'd0, trigger}, 32'd1);
    $display("seq skip: trigger=%b after strobe 101", trigger);

    // Window of 80: 79 low, one high, then 80 low.
    seen = 0; pulses = 0;
    sample_in = 32'd0;
    for (int k = 0; k < 79; k++) begin tick(); seen |= ~trigger; pulses += sync_short_reset; end
    sample_in = {16'd2000, 16'd0};
    tick(); seen |= ~trigger; pulses += sync_short_reset;
    sample_in = 32'd0;
    for (int k = 0; k < 79; k++) begin tick(); seen |= ~trigger; pulses += sync_short_reset; end
    check("window_hold", {31'd0, seen}, 32'd0);
    tick(); pulses += sync_short_reset;
    check("window_close", {30'd0, trigger, sync_short_reset}, 32'd1);
    sample_in_strobe = 0;
    tick(); pulses += sync_short_reset;
    check("window_pulse_count", pulses, 32'd1);
    $display("seq window: ssr pulses=%0d", pulses);

    // Demodulation in progress holds the packet open.
    sample_in = {16'd2000, 16'd0}; sample_in_strobe = 1;
    tick();
    check("demod_open", {31'd0, trigger}, 32'd1);
    demod_is_ongoing = 1; sample_in = 32'd0; seen = 0;
    for (int k = 0; k < 200; k++) begin tick(); seen |= ~trigger | sync_short_reset; end
    check("demod_hold", {31'd0, seen}, 32'd0);
    demod_is_ongoing = 0; sample_in_strobe = 0;
    tick();
    check("demod_fall_idle", {31'd0, trigger}, 32'd1);
    sample_in_strobe = 1;
    tick();
    check("demod_close", {30'd0, trigger, sync_short_reset}, 32'd1);
    $display("seq demod: trig=%b ssr=%b", trigger, sync_short_reset);

    // Reconfiguration pulse during a packet, coincident with a strong sample.
    sample_in = {16'hF000, 16'd0};
    tick();
    check("nsc_open", {31'd0, trigger}, 32'd1);
    num_sample_to_skip = 32'd3; num_sample_changed = 1;
    tick();
    check("nsc_close", {30'd0, trigger, sync_short_reset}, 32'd1);
    num_sample_changed = 0; seen = 0;
    for (int k = 0; k < 3; k++) begin tick(); seen |= trigger; end
    check("nsc_skip", {31'd0, seen}, 32'd0);
    tick();
    check("nsc_reopen", {31'd0, trigger}, 32'd1);
    $display("seq nsc: trig=%b after re-skip", trigger);

    // Asynchronous reset mid-packet.
    #2;
    reset = 1;
    #1;
    check("areset_trigger", {30'd0, trigger, sync_short_reset}, 32'd0);
    tick(); tick();
    reset = 0; sample_in_strobe = 0; seen = 0; seen2 = 0;
    for (int k = 0; k < 5; k++) begin tick(); seen |= sync_short_reset; seen2 |= trigger; end
    check("areset_no_pulse", {30'd0, seen2, seen}, 32'd0);
    $display("seq areset: trig=%b", trigger);

    // Randomized run against the model.
    for (int seg = 0; seg < 6; seg++) begin
      int seg_err;
      seg_err = errors;
      apply_reset();
      case ($urandom_range(0, 3))
        0: power_thres = 16'd1000;
        1: power_thres = 16'd32766;
        2: power_thres = 16'd0;
        default: power_thres = 16'($urandom);
      endcase
      window_size = 16'($urandom_range(0, 5));
      num_sample_to_skip = $urandom_range(0, 4);
      for (int c = 0; c < 500; c++) begin
        logic [15:0] iv;
        case ($urandom_range(0, 3))
          0: iv = 16'($urandom);
          1: iv = 16'($urandom_range(0, 1500));
          2: iv = 16'h8000;
          default: iv = 16'h7FFF - 16'($urandom_range(0, 2));
        endcase
        if ($urandom_range(0, 1) == 1) iv = ~iv + 16'd1;
        sample_in = {iv, 16'($urandom)};
        enable = ($urandom_range(0, 19) != 0);
        sample_in_strobe = ($urandom_range(0, 9) < 6);
        num_sample_changed = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 19) == 0) demod_is_ongoing = ~demod_is_ongoing;
        if ($urandom_range(0, 99) == 0) window_size = 16'($urandom_range(0, 5));
        tick();
        model_step();
        check($sformatf("rand%0d_%0d", seg, c), {30'd0, trigger, sync_short_reset},
              {30'd0, m_trig, m_ssr});
      end
      $display("random segment %0d: thr=%0d win=%0d skip=%0d new_errors=%0d",
               seg, power_thres, window_size, num_sample_to_skip, errors - seg_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
